// File: rtl/expipe_pkg.sv
// ---------------------------------------------------------------------------
// expipe_pkg
// Shared types and constants for the issue-stage instruction queue.
//   XLEN / ILEN      : PC and instruction word widths
//   ISSUE_Q_DEPTH    : default number of queue entries
//   except_code_t    : fetch exception code
//   iq_entry_t       : one buffered instruction with prediction/exception info
//   iq_ptr_w()       : pointer width for a given depth (at least 1 bit)
// ---------------------------------------------------------------------------
package expipe_pkg;

    localparam int XLEN          = 32;
    localparam int ILEN          = 32;
    localparam int EXCEPT_CODE_W = 5;
    localparam int ISSUE_Q_DEPTH = 4;

    typedef logic [EXCEPT_CODE_W-1:0] except_code_t;

    typedef struct packed {
        logic [XLEN-1:0] curr_pc;
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pred_target;
        logic            pred_taken;
        logic            except_raised;
        except_code_t    except_code;
    } iq_entry_t;

    function automatic int iq_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/iq_ptr_ctrl.sv
// ---------------------------------------------------------------------------
// iq_ptr_ctrl
// Head/tail pointers and occupancy counter for a DEPTH-entry circular buffer.
// Pointers wrap DEPTH-1 -> 0 explicitly, so DEPTH need not be a power of two.
// Ports:
//   clk_i, rst_n_i   clock, synchronous active-low reset
//   flush_i          synchronous clear of pointers and count (dominates)
//   push_i, pop_i    qualified write / read strobes
//   head_o, tail_o   read / write entry index
//   occupancy_o      number of valid entries
//   full_o, empty_o  occupancy == DEPTH / occupancy == 0
//   afull_o          free entries <= AFULL_TH
// ---------------------------------------------------------------------------
module iq_ptr_ctrl
    import expipe_pkg::*;
#(
    parameter int DEPTH    = ISSUE_Q_DEPTH,
    parameter int AFULL_TH = 1,
    parameter int PTR_W    = iq_ptr_w(DEPTH),
    parameter int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    output logic [PTR_W-1:0] head_o,
    output logic [PTR_W-1:0] tail_o,
    output logic [CNT_W-1:0] occupancy_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             afull_o
);

    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    // free <= AFULL_TH  <=>  occupancy >= DEPTH - AFULL_TH (avoids a subtraction)
    localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(DEPTH - AFULL_TH);

    logic [PTR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i || flush_i) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_i)
                tail_q <= (tail_q == LAST_IDX) ? '0 : tail_q + 1'b1;
            if (pop_i)
                head_q <= (head_q == LAST_IDX) ? '0 : head_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign head_o      = head_q;
    assign tail_o      = tail_q;
    assign occupancy_o = cnt_q;
    assign full_o      = (cnt_q == FULL_CNT);
    assign empty_o     = (cnt_q == '0);
    assign afull_o     = (cnt_q >= AFULL_CNT);

endmodule

// File: rtl/issue_queue_param.sv
// ---------------------------------------------------------------------------
// issue_queue_param
// Multi-entry FIFO between the fetch unit and the issue logic.
// Once an excepting instruction is accepted, fetch intake is locked until
// flush_i or reset; the queue keeps draining meanwhile.
// Optional macro LEN5_ISSUE_BYPASS_EN: when the queue is empty and unlocked,
// the fetch instruction is forwarded combinationally to the issue side and
// is not stored if issue consumes it in the same cycle.
// Ports:
//   clk_i, rst_n_i, flush_i            clock, sync active-low reset, sync flush
//   fetch_*                            fetch handshake and instruction fields
//   issue_ready_i / issue_valid_o      issue handshake
//   curr_pc_o .. except_code_o         head entry fields
//   occupancy_o, almost_full_o         fill level reporting
// ---------------------------------------------------------------------------
module issue_queue_param
    import expipe_pkg::*;
#(
    parameter int DEPTH    = ISSUE_Q_DEPTH,
    parameter int AFULL_TH = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       flush_i,
    input  logic                       fetch_valid_i,
    output logic                       fetch_ready_o,
    input  logic [XLEN-1:0]            fetch_curr_pc_i,
    input  logic [ILEN-1:0]            fetch_instr_i,
    input  logic [XLEN-1:0]            fetch_pred_target_i,
    input  logic                       fetch_pred_taken_i,
    input  logic                       fetch_except_raised_i,
    input  except_code_t               fetch_except_code_i,
    input  logic                       issue_ready_i,
    output logic                       issue_valid_o,
    output logic [XLEN-1:0]            curr_pc_o,
    output logic [ILEN-1:0]            instruction_o,
    output logic [XLEN-1:0]            pred_target_o,
    output logic                       pred_taken_o,
    output logic                       except_raised_o,
    output except_code_t               except_code_o,
    output logic [$clog2(DEPTH+1)-1:0] occupancy_o,
    output logic                       almost_full_o
);

    localparam int PTR_W = iq_ptr_w(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    iq_entry_t        mem_q [DEPTH];
    iq_entry_t        fetch_entry;
    iq_entry_t        head_entry;
    logic [PTR_W-1:0] head, tail;
    logic             full, empty;
    logic             lock_q;
    logic             accept;
    logic             push, pop;

    assign fetch_entry = '{
        curr_pc:       fetch_curr_pc_i,
        instr:         fetch_instr_i,
        pred_target:   fetch_pred_target_i,
        pred_taken:    fetch_pred_taken_i,
        except_raised: fetch_except_raised_i,
        except_code:   fetch_except_code_i
    };

    // No same-cycle pass-through when full: ready depends on registers only.
    assign fetch_ready_o = ~full & ~lock_q;
    assign accept        = fetch_valid_i & fetch_ready_o & ~flush_i;
    // Stored entries only; a bypassed instruction never touches the pointers.
    assign pop           = ~empty & issue_ready_i & ~flush_i;

`ifdef LEN5_ISSUE_BYPASS_EN
    logic bypass;
    assign bypass        = empty & ~lock_q & fetch_valid_i & ~flush_i;
    assign issue_valid_o = ~empty | bypass;
    assign head_entry    = bypass ? fetch_entry : mem_q[head];
    assign push          = accept & ~(bypass & issue_ready_i);
`else
    assign issue_valid_o = ~empty;
    assign head_entry    = mem_q[head];
    assign push          = accept;
`endif

    iq_ptr_ctrl #(
        .DEPTH    (DEPTH),
        .AFULL_TH (AFULL_TH),
        .PTR_W    (PTR_W),
        .CNT_W    (CNT_W)
    ) u_ptr_ctrl (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .flush_i     (flush_i),
        .push_i      (push),
        .pop_i       (pop),
        .head_o      (head),
        .tail_o      (tail),
        .occupancy_o (occupancy_o),
        .full_o      (full),
        .empty_o     (empty),
        .afull_o     (almost_full_o)
    );

    // Entries are cleared only on reset so the head reads zero afterwards;
    // flush just rewinds the pointers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
        end else if (push) begin
            mem_q[tail] <= fetch_entry;
        end
    end

    // Lock is set by any accepted excepting instruction, bypassed or stored.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || flush_i)
            lock_q <= 1'b0;
        else if (accept && fetch_except_raised_i)
            lock_q <= 1'b1;
    end

    assign curr_pc_o       = head_entry.curr_pc;
    assign instruction_o   = head_entry.instr;
    assign pred_target_o   = head_entry.pred_target;
    assign pred_taken_o    = head_entry.pred_taken;
    assign except_raised_o = head_entry.except_raised;
    assign except_code_o   = head_entry.except_code;

endmodule

// File: tb/tb_issue_queue_param.sv
module tb_issue_queue_param;
    import expipe_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] tgt;
        logic        tk;
        logic        exc;
        logic [4:0]  code;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // DEPTH=4 instance (f_*) and DEPTH=3 instance (g_*)
    logic        f_flush = 0, f_valid = 0, f_taken = 0, f_exc = 0, f_rdy = 0;
    logic [31:0] f_pc = 0, f_instr = 0, f_target = 0;
    logic [4:0]  f_code = 0;
    logic        f_ready, f_ivalid, f_otk, f_oexc, f_af;
    logic [31:0] f_opc, f_oinstr, f_otgt;
    logic [4:0]  f_ocode;
    logic [2:0]  f_occ;

    logic        g_flush = 0, g_valid = 0, g_taken = 0, g_exc = 0, g_rdy = 0;
    logic [31:0] g_pc = 0, g_instr = 0, g_target = 0;
    logic [4:0]  g_code = 0;
    logic        g_ready, g_ivalid, g_otk, g_oexc, g_af;
    logic [31:0] g_opc, g_oinstr, g_otgt;
    logic [4:0]  g_ocode;
    logic [1:0]  g_occ;

    int n_cmp = 0;
    int n_fail = 0;
    exp_t exp4[$];
    exp_t exp3[$];

    issue_queue_param #(.DEPTH(4), .AFULL_TH(1)) u4 (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(f_flush),
        .fetch_valid_i(f_valid), .fetch_ready_o(f_ready),
        .fetch_curr_pc_i(f_pc), .fetch_instr_i(f_instr),
        .fetch_pred_target_i(f_target), .fetch_pred_taken_i(f_taken),
        .fetch_except_raised_i(f_exc), .fetch_except_code_i(f_code),
        .issue_ready_i(f_rdy), .issue_valid_o(f_ivalid),
        .curr_pc_o(f_opc), .instruction_o(f_oinstr), .pred_target_o(f_otgt),
        .pred_taken_o(f_otk), .except_raised_o(f_oexc), .except_code_o(f_ocode),
        .occupancy_o(f_occ), .almost_full_o(f_af));

    issue_queue_param #(.DEPTH(3), .AFULL_TH(1)) u3 (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(g_flush),
        .fetch_valid_i(g_valid), .fetch_ready_o(g_ready),
        .fetch_curr_pc_i(g_pc), .fetch_instr_i(g_instr),
        .fetch_pred_target_i(g_target), .fetch_pred_taken_i(g_taken),
        .fetch_except_raised_i(g_exc), .fetch_except_code_i(g_code),
        .issue_ready_i(g_rdy), .issue_valid_o(g_ivalid),
        .curr_pc_o(g_opc), .instruction_o(g_oinstr), .pred_target_o(g_otgt),
        .pred_taken_o(g_otk), .except_raised_o(g_oexc), .except_code_o(g_ocode),
        .occupancy_o(g_occ), .almost_full_o(g_af));

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hDEAD_0000;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endfunction

    // Scoreboard monitors: compare the head on every issue handshake.
    always @(negedge clk) begin
        if (rst_n && !f_flush && f_ivalid && f_rdy) begin
            if (exp4.size() == 0) begin
                chk("q4_unexpected_issue", f_opc, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp4.pop_front();
                chk("q4_pc", f_opc, e.pc);
                chk("q4_instr", f_oinstr, e.instr);
                chk("q4_target", f_otgt, e.tgt);
                chk("q4_taken", {31'b0, f_otk}, {31'b0, e.tk});
                chk("q4_exc", {31'b0, f_oexc}, {31'b0, e.exc});
                chk("q4_code", {27'b0, f_ocode}, {27'b0, e.code});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && !g_flush && g_ivalid && g_rdy) begin
            if (exp3.size() == 0) begin
                chk("q3_unexpected_issue", g_opc, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp3.pop_front();
                chk("q3_pc", g_opc, e.pc);
                chk("q3_instr", g_oinstr, e.instr);
                chk("q3_exc", {31'b0, g_oexc}, {31'b0, e.exc});
            end
        end
    end

    // Drive one cycle of inputs just after posedge, return at the following
    // negedge (inputs still applied; registered state is from before this cycle).
    task automatic step(input int sel, input logic v, input logic [31:0] pc,
                        input logic exc, input logic [4:0] code,
                        input logic rdy, input logic fl, input logic exp_push);
        exp_t e;
        @(posedge clk); #1;
        e.pc = pc; e.instr = instr_of(pc); e.tgt = pc + 32'h40;
        e.tk = pc[2]; e.exc = exc; e.code = code;
        if (sel == 0) begin
            f_valid = v; f_pc = pc; f_instr = e.instr; f_target = e.tgt;
            f_taken = e.tk; f_exc = exc; f_code = code; f_rdy = rdy; f_flush = fl;
            if (exp_push) exp4.push_back(e);
            if (fl) exp4.delete();
        end else begin
            g_valid = v; g_pc = pc; g_instr = e.instr; g_target = e.tgt;
            g_taken = e.tk; g_exc = exc; g_code = code; g_rdy = rdy; g_flush = fl;
            if (exp_push) exp3.push_back(e);
            if (fl) exp3.delete();
        end
        @(negedge clk);
    endtask

    task automatic idle(input int sel);
        step(sel, 0, 32'h0, 0, 5'h0, 0, 0, 0);
    endtask

    initial begin
        // ---- reset ----
        idle(0); idle(0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        chk("rst_fetch_ready", {31'b0, f_ready}, 32'd1);
        chk("rst_issue_valid", {31'b0, f_ivalid}, 32'd0);
        chk("rst_occupancy", {29'b0, f_occ}, 32'd0);
        chk("rst_almost_full", {31'b0, f_af}, 32'd0);
        chk("rst_curr_pc", f_opc, 32'd0);
        chk("rst_instr", f_oinstr, 32'd0);
        chk("rst_q3_ready", {31'b0, g_ready}, 32'd1);

        // ---- test 1: fill DEPTH=4, no pops ----
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 32'h100 + 32'(4*i), 0, 5'h0, 0, 0, 1);
            chk("t1_occupancy", {29'b0, f_occ}, 32'(i));
            chk("t1_almost_full", {31'b0, f_af}, (i >= 3) ? 32'd1 : 32'd0);
            chk("t1_fetch_ready", {31'b0, f_ready}, 32'd1);
        end
        step(0, 1, 32'h1FC, 0, 5'h0, 0, 0, 0);   // rejected: queue full
        chk("t1_full_occupancy", {29'b0, f_occ}, 32'd4);
        chk("t1_full_ready", {31'b0, f_ready}, 32'd0);
        chk("t1_full_afull", {31'b0, f_af}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 32'h0, 0, 5'h0, 1, 0, 0);
            chk("t1_drain_occupancy", {29'b0, f_occ}, 32'(4 - i));
        end
        idle(0);
        chk("t1_empty_valid", {31'b0, f_ivalid}, 32'd0);
        chk("t1_empty_occupancy", {29'b0, f_occ}, 32'd0);
        chk("t1_sb_empty", 32'(exp4.size()), 32'd0);

        // ---- test 2: steady push+pop at occupancy 3 ----
        for (int i = 0; i < 3; i++)
            step(0, 1, 32'h300 + 32'(4*i), 0, 5'h0, 0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 32'h30C + 32'(4*i), 0, 5'h0, 1, 0, 1);
            chk("t2_occupancy", {29'b0, f_occ}, 32'd3);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 32'h0, 0, 5'h0, 1, 0, 0);
            chk("t2_drain_occupancy", {29'b0, f_occ}, 32'(3 - i));
        end
        idle(0);
        chk("t2_occupancy_end", {29'b0, f_occ}, 32'd0);
        chk("t2_sb_empty", 32'(exp4.size()), 32'd0);

        // ---- test 3: wrap on DEPTH=3 ----
        step(1, 1, 32'h400, 0, 5'h0, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 32'h404 + 32'(4*i), 0, 5'h0, 1, 0, 1);
            chk("t3_occupancy", {30'b0, g_occ}, 32'd1);
        end
        step(1, 0, 32'h0, 0, 5'h0, 1, 0, 0);
        chk("t3_occupancy_last", {30'b0, g_occ}, 32'd1);
        idle(1);
        chk("t3_occupancy_end", {30'b0, g_occ}, 32'd0);
        chk("t3_sb_empty", 32'(exp3.size()), 32'd0);

        // ---- test 4: exception lock ----
        step(0, 1, 32'h200, 1, 5'h0B, 0, 0, 1);
        step(0, 1, 32'h204, 0, 5'h0, 0, 0, 0);   // rejected: locked
        chk("t4_locked_ready", {31'b0, f_ready}, 32'd0);
        chk("t4_occupancy", {29'b0, f_occ}, 32'd1);
        step(0, 1, 32'h208, 0, 5'h0, 1, 0, 0);   // drain excepting entry
        chk("t4_occupancy_hold", {29'b0, f_occ}, 32'd1);
        chk("t4_head_exc", {31'b0, f_oexc}, 32'd1);
        chk("t4_head_code", {27'b0, f_ocode}, 32'h0B);
        step(0, 1, 32'h20C, 0, 5'h0, 0, 0, 0);
        chk("t4_drained_occupancy", {29'b0, f_occ}, 32'd0);
        chk("t4_drained_valid", {31'b0, f_ivalid}, 32'd0);
        chk("t4_still_locked", {31'b0, f_ready}, 32'd0);
        step(0, 1, 32'h210, 0, 5'h0, 0, 1, 0);   // flush
        idle(0);
        chk("t4_flush_ready", {31'b0, f_ready}, 32'd1);
        chk("t4_flush_occupancy", {29'b0, f_occ}, 32'd0);

        // ---- test 5: flush beats same-cycle push/pop ----
        step(0, 1, 32'h500, 0, 5'h0, 0, 0, 1);
        step(0, 1, 32'h504, 0, 5'h0, 0, 0, 1);
        step(0, 1, 32'h508, 0, 5'h0, 1, 1, 0);
        chk("t5_pre_occupancy", {29'b0, f_occ}, 32'd2);
        idle(0);
        chk("t5_occupancy", {29'b0, f_occ}, 32'd0);
        chk("t5_valid", {31'b0, f_ivalid}, 32'd0);
        chk("t5_ready", {31'b0, f_ready}, 32'd1);

        // ---- test 6: empty-queue latency ----
        step(0, 1, 32'h600, 0, 5'h0, 1, 0, 1);
`ifdef LEN5_ISSUE_BYPASS_EN
        chk("t6_bypass_valid", {31'b0, f_ivalid}, 32'd1);
        chk("t6_bypass_pc", f_opc, 32'h600);
        chk("t6_bypass_occupancy", {29'b0, f_occ}, 32'd0);
        idle(0);
        chk("t6_after_occupancy", {29'b0, f_occ}, 32'd0);
        chk("t6_after_valid", {31'b0, f_ivalid}, 32'd0);
`else
        chk("t6_same_cycle_valid", {31'b0, f_ivalid}, 32'd0);
        step(0, 0, 32'h0, 0, 5'h0, 1, 0, 0);
        chk("t6_next_cycle_valid", {31'b0, f_ivalid}, 32'd1);
        chk("t6_next_cycle_pc", f_opc, 32'h600);
        idle(0);
        chk("t6_after_occupancy", {29'b0, f_occ}, 32'd0);
`endif
        chk("final_sb4_empty", 32'(exp4.size()), 32'd0);
        chk("final_sb3_empty", 32'(exp3.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
